// File: rtl/pcie_datalink_pkg.sv
// Shared data-link definitions for the TLP framer: FSM codes, LCRC constants and helpers,
// and the layout of the sequence prefix DW.
package pcie_datalink_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEQ  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_LCRC = 2'd3;

   localparam logic [31:0] LCRC_POLY = 32'h04C1_1DB7;
   localparam logic [31:0] LCRC_INIT = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [15:0] rsvd_hi;
      logic [3:0]  rsvd_lo;
      logic [11:0] seq;
   } dll_seq_prefix_t;

   // Bits of each byte enter the register LSB first.
   function automatic logic [31:0] lcrc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ LCRC_POLY;
         else                 c = {c[30:0], 1'b0};
      end
      return c;
   endfunction

   // Complement, then mirror the bits inside every byte so wire byte 0 lands in [31:24].
   function automatic logic [31:0] lcrc_final(input logic [31:0] crc);
      logic [31:0] c;
      logic [31:0] r;
      c = ~crc;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 8; j++) begin
            r[8*k+j] = c[8*k+7-j];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/pcie_tlp_seq_lcrc_framer_if.sv
// AXI-Stream bundle used on both sides of the TLP framer.
// Handshake: a beat transfers on a rising clock edge where tvalid && tready; once tvalid is high the
// master holds tdata/tkeep/tlast/tuser stable and keeps tvalid high until that transfer happens.
interface pcie_tlp_seq_lcrc_framer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int USER_WIDTH = 1
);
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tlast;
   logic [USER_WIDTH-1:0] tuser;
   logic                  tready;

   modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/pcie_lcrc32_dw.sv
// Combinational LCRC advance over one DW: all four bytes, or only the low two (sequence prefix).
module pcie_lcrc32_dw
   import pcie_datalink_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [31:0] data_i,
   input  logic [2:0]  byte_cnt_i,
   output logic [31:0] crc_o
);
   always_comb begin
      crc_o = crc_i;
      if (byte_cnt_i == 3'd4) begin
         crc_o = lcrc32_byte(crc_o, data_i[31:24]);
         crc_o = lcrc32_byte(crc_o, data_i[23:16]);
      end
      crc_o = lcrc32_byte(crc_o, data_i[15:8]);
      crc_o = lcrc32_byte(crc_o, data_i[7:0]);
   end
endmodule

// File: rtl/pcie_tlp_seq_lcrc_framer.sv
// DLL TX framer: wraps each AXIS TLP in a sequence prefix DW and a trailing LCRC DW.
// Define TLP_FRAMER_NULLIFY_EN to honour tuser[0] on tlast as nullify (inverted LCRC, no seq advance).
module pcie_tlp_seq_lcrc_framer
   import pcie_datalink_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int USER_WIDTH = 1,
   parameter int SEQ_WIDTH  = 12
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   pcie_tlp_seq_lcrc_framer_if.slave  s_axis,
   pcie_tlp_seq_lcrc_framer_if.master m_axis,
   input  logic                       seq_load_i,
   input  logic [SEQ_WIDTH-1:0]       seq_load_val_i,
   output logic [SEQ_WIDTH-1:0]       next_seq_o,
   output logic [1:0]                 dbg_state_o
);
   if (DATA_WIDTH != 32) begin : g_width_check
      $error("pcie_tlp_seq_lcrc_framer supports DATA_WIDTH == 32 only");
   end

   logic [1:0]            state;
   logic [31:0]           crc_q, crc_in, crc_data, crc_out;
   logic [2:0]            crc_bytes;
   logic                  keep_err_q, nullify_q;
   logic [SEQ_WIDTH-1:0]  next_seq_q;
   logic                  m_valid_q, m_last_q;
   logic [31:0]           m_data_q;
   logic [USER_WIDTH-1:0] m_user_q;
   logic                  slot_free, s_fire;
   dll_seq_prefix_t       prefix;
   logic                  unused_tuser;

   // The single output slot may be reloaded whenever it is empty or being drained this cycle.
   assign slot_free     = !m_valid_q || m_axis.tready;
   assign s_axis.tready = (state == ST_DATA) && slot_free;
   assign s_fire        = s_axis.tvalid && s_axis.tready;
   assign unused_tuser  = ^s_axis.tuser;

   always_comb begin
      prefix     = '0;
      prefix.seq = 12'(next_seq_q);
      crc_bytes  = 3'd2;
      crc_in     = LCRC_INIT;
      crc_data   = prefix;
      if (state == ST_DATA) begin
         crc_bytes = 3'd4;
         crc_in    = crc_q;
         crc_data  = s_axis.tdata;
      end
   end

   pcie_lcrc32_dw u_lcrc (
      .crc_i      (crc_in),
      .data_i     (crc_data),
      .byte_cnt_i (crc_bytes),
      .crc_o      (crc_out)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         crc_q      <= LCRC_INIT;
         keep_err_q <= 1'b0;
         nullify_q  <= 1'b0;
         next_seq_q <= '0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
         m_data_q   <= '0;
         m_user_q   <= '0;
      end else begin
         if (slot_free) m_valid_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (seq_load_i) next_seq_q <= seq_load_val_i;
               if (s_axis.tvalid) state <= ST_SEQ;
            end
            ST_SEQ: if (slot_free) begin
               m_valid_q  <= 1'b1;
               m_data_q   <= prefix;
               m_last_q   <= 1'b0;
               m_user_q   <= '0;
               crc_q      <= crc_out;
               keep_err_q <= 1'b0;
               nullify_q  <= 1'b0;
               state      <= ST_DATA;
            end
            ST_DATA: if (s_fire) begin
               m_valid_q <= 1'b1;
               m_data_q  <= s_axis.tdata;
               m_last_q  <= 1'b0;
               m_user_q  <= '0;
               crc_q     <= crc_out;
               if (s_axis.tkeep != {KEEP_WIDTH{1'b1}}) keep_err_q <= 1'b1;
               if (s_axis.tlast) begin
`ifdef TLP_FRAMER_NULLIFY_EN
                  nullify_q <= s_axis.tuser[0];
`else
                  nullify_q <= 1'b0;
`endif
                  state <= ST_LCRC;
               end
            end
            default: if (slot_free) begin
               m_valid_q <= 1'b1;
               m_data_q  <= lcrc_final(crc_q) ^ {32{nullify_q}};
               m_last_q  <= 1'b1;
               m_user_q  <= USER_WIDTH'(keep_err_q);
               // A nullified TLP never enters the replay buffer, so it consumes no sequence number.
               if (!nullify_q) next_seq_q <= next_seq_q + 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign m_axis.tvalid = m_valid_q;
   assign m_axis.tdata  = m_data_q;
   assign m_axis.tlast  = m_last_q;
   assign m_axis.tuser  = m_user_q;
   assign m_axis.tkeep  = {KEEP_WIDTH{m_valid_q}};
   assign next_seq_o    = next_seq_q;
   assign dbg_state_o   = state;
endmodule
